// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
// Bundles the data/control inputs and the display outputs of
// seg7_scan_display.
//
// Signals (NUM_DIGITS = digit count):
//   value      [4*NUM_DIGITS-1:0]  nibble i is digit i, digit 0 least significant
//   load                           capture strobe for value
//   hex_mode                       1 = A-F glyphs, 0 = codes 10-15 blank
//   blank_lz                       1 = suppress leading zeros
//   blink_mask [NUM_DIGITS-1:0]    bit i = 1 makes digit i blink
//   hex_all    [7*NUM_DIGITS-1:0]  static per-digit segments, active-low
//   seg        [6:0]               segments of the scanned digit, active-low
//   dig_n      [NUM_DIGITS-1:0]    active-low one-hot digit enable
//
// Handshake: there is no valid/ready pair. load is a plain level-sampled
// strobe: every rising clock edge that sees load=1 captures value, and the
// display can never stall the source.
//
// Modports: master drives the inputs (testbench / host logic),
//           slave is the display block.
// ---------------------------------------------------------------------------
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    hex_mode;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [7*NUM_DIGITS-1:0] hex_all;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_n;

    modport master (
        output value, load, hex_mode, blank_lz, blink_mask,
        input  hex_all, seg, dig_n
    );

    modport slave (
        input  value, load, hex_mode, blank_lz, blink_mask,
        output hex_all, seg, dig_n
    );
endinterface

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
// Multi-digit 7-segment driver. A shadow register holds the value to show;
// every digit is decoded into a static, registered glyph bus (hex_all) and a
// scan counter walks a digit pointer that selects one glyph onto the
// multiplexed seg/dig_n outputs. Supports hex glyphs, leading-zero blanking
// and per-digit blinking.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of seg7_scan_display_if (value, load, hex_mode,
//               blank_lz, blink_mask in; hex_all, seg, dig_n out)
//
// Segment order everywhere: bit 0 = a ... bit 6 = g, 0 = segment lit.
// ---------------------------------------------------------------------------
module seg7_scan_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_display_if.slave   bus
);

    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // Glyph tables are written in a..g reading order (leftmost = segment a);
    // this flips them into bus order where bit 0 is segment a.
    function automatic logic [6:0] abcdefg(input logic [6:0] pat);
        logic [6:0] r;
        for (int k = 0; k < 7; k++) begin
            r[k] = pat[6-k];
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] code, input logic hex);
        logic [6:0] g;
        case (code)
            4'd0:    g = abcdefg(7'b0000001);
            4'd1:    g = abcdefg(7'b1001111);
            4'd2:    g = abcdefg(7'b0010010);
            4'd3:    g = abcdefg(7'b0000110);
            4'd4:    g = abcdefg(7'b1001100);
            4'd5:    g = abcdefg(7'b0100100);
            4'd6:    g = abcdefg(7'b0100000);
            4'd7:    g = abcdefg(7'b0001101);
            4'd8:    g = abcdefg(7'b0000000);
            4'd9:    g = abcdefg(7'b0000100);
            4'd10:   g = hex ? abcdefg(7'b0001000) : 7'h7f;
            4'd11:   g = hex ? abcdefg(7'b1100000) : 7'h7f;
            4'd12:   g = hex ? abcdefg(7'b0110001) : 7'h7f;
            4'd13:   g = hex ? abcdefg(7'b1000010) : 7'h7f;
            4'd14:   g = hex ? abcdefg(7'b0110000) : 7'h7f;
            default: g = hex ? abcdefg(7'b0111000) : 7'h7f;
        endcase
        return g;
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]        scan_cnt;
    logic [PTR_W-1:0]        ptr;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_phase;
    logic [7*NUM_DIGITS-1:0] hex_all_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   dig_n_q;

    logic                    scan_tick;
    logic [7*NUM_DIGITS-1:0] glyphs;
    logic                    upper_nz;
    logic [3:0]              nib;
    logic                    blank;

    assign scan_tick = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    // Decode from the top digit down so upper_nz tells whether this digit or
    // any more significant one is non-zero; digit 0 is never zero-suppressed.
    always_comb begin
        upper_nz = 1'b0;
        nib      = 4'd0;
        blank    = 1'b0;
        glyphs   = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib      = shadow[4*i +: 4];
            upper_nz = upper_nz | (nib != 4'd0);
            blank    = ((i != 0) && bus.blank_lz && !upper_nz)
                     || (bus.blink_mask[i] && blink_phase);
            glyphs[7*i +: 7] = blank ? 7'h7f : glyph(nib, bus.hex_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            scan_cnt    <= '0;
            ptr         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            hex_all_q   <= '1;
            seg_q       <= 7'h7f;
            dig_n_q     <= '1;
        end else begin
            if (bus.load) begin
                shadow <= bus.value;
            end

            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;

            if (scan_tick) begin
                ptr <= (ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
                if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            hex_all_q <= glyphs;

            // seg and dig_n come from the same pointer value in the same edge,
            // so the enabled digit and its segments never disagree.
            seg_q   <= hex_all_q[7*int'(ptr) +: 7];
            dig_n_q <= ~(NUM_DIGITS'(1) << ptr);
        end
    end

    assign bus.hex_all = hex_all_q;
    assign bus.seg     = seg_q;
    assign bus.dig_n   = dig_n_q;

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter: NUM_DIGITS, default 4, digit count (legal 1..8).
REQ-002 Parameter: SCAN_DIV, default 50000, clocks per digit scan slot (legal >=2).
REQ-003 Parameter: BLINK_TICKS, default 64, scan-slot wraps per blink half-period (legal >=1).
REQ-004 Port: clk  in  1  system clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: value  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
REQ-007 Port: load  in  1  strobe; value is captured into the shadow register on a clock edge with load=1.
REQ-008 Port: hex_mode  in  1  1 = show A-F glyphs; 0 = codes 10-15 blank.
REQ-009 Port: blank_lz  in  1  1 = suppress leading zeros.
REQ-010 Port: blink_mask  in  NUM_DIGITS  bit i = 1 makes digit i blink.
REQ-011 Port: hex_all  out  7*NUM_DIGITS  static per-digit segments; digit i at bits 7i+6:7i, bit 7i = segment a ... bit 7i+6 = segment g, active-low.
REQ-012 Port: seg  out  7  multiplexed segments of currently scanned digit, same order and polarity.
REQ-013 Port: dig_n  out  NUM_DIGITS  active-low one-hot digit enable for the scanned digit.

Function
REQ-014 Glyphs (a..g, 0 = lit) SHALL be: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001101, 8 0000000, 9 0000100.
REQ-015 With hex_mode=1: A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000; with hex_mode=0 codes 10-15 SHALL produce 1111111.
REQ-016 Shadow register SHALL change only on load=1 edges; load held high recaptures every cycle.
REQ-017 Leading-zero: with blank_lz=1, digit i (i>=1) SHALL be 1111111 when shadow digits i..NUM_DIGITS-1 are all 0; digit 0 never suppressed (value 0 shows "0").
REQ-018 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; the wrap cycle is a scan tick.
REQ-019 On each scan tick digit pointer SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-020 Blink counter SHALL count scan ticks; after BLINK_TICKS ticks blink_phase SHALL toggle and the counter restart at 0.
REQ-021 Digit i with blink_mask[i]=1 SHALL be 1111111 while blink_phase=1; blink_mask=0 digits are unaffected.
REQ-022 Blank precedence: blank if any of leading-zero, blink, or non-decimal-in-decimal-mode applies.
REQ-023 hex_all SHALL be registered: load sampled at edge t -> new glyphs at hex_all after edge t+1 (latency 2 edges from load assertion).
REQ-024 hex_mode, blank_lz, blink_mask changes SHALL reach hex_all after one edge.
REQ-025 seg and dig_n SHALL be registered together from the pointer and hex_all, updating one edge after pointer change; dig_n SHALL never have more than one 0 bit.
REQ-026 Load coinciding with a scan tick SHALL take effect per REQ-023 without disturbing pointer advance.
REQ-027 NUM_DIGITS=1: pointer stays 0, dig_n constant 0 after first post-reset edge.

Reset
REQ-028 rst_n=0 SHALL immediately clear shadow, scan counter, pointer, blink counter, blink_phase to 0 and force hex_all all-ones, seg 1111111, dig_n all-ones.
REQ-029 Reset asserted mid-scan SHALL abort the slot; after release the first edge restarts scanning at digit 0 with counter 0.
REQ-030 After release with no load, displayed value SHALL be 0 (digit0 "0", others "0" or blanked per blank_lz).

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_TICKS=2)
REQ-031 load value=16'h1239, hex_mode=0 -> two edges later hex_all digits 3..0 = 1001111, 0010010, 0000110, 0000100.
REQ-032 load 16'h00AF, hex_mode=1, blank_lz=1 -> digit1 0001000, digit0 0111000, digits 3,2 1111111; hex_mode=0 -> digits 1,0 1111111 after one edge.
REQ-033 free-run 16 cycles -> dig_n sequence 1110,1101,1011,0111 each held 4 cycles, seg matching hex_all slice of the enabled digit.
REQ-034 blink_mask=4'b0001, value 16'h0005 -> digit0 alternates 0100100 / 1111111 every 8 clocks; digits 3..1 constant.
REQ-035 rst_n low for 1 cycle mid-slot with digit2 scanned -> outputs blank immediately; first post-release edges show digit 0, value 0.
